// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit and its HI/LO registers.
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on a 2*XLEN accumulator against a held operand.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN:0]     add_sum;
    logic [XLEN+1:0]   sub_diff;

    // Divide trial uses XLEN+1 bits of partial remainder so the shifted-out MSB is kept.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        sub_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
        acc_d    = acc_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
        end else if (step_i) begin
            if (!div_i) begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end else if (!sub_diff[XLEN+1]) begin
                acc_d = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opb_q <= b_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO: FSM, operand sign handling,
// flush and HI/LO commit around the shared iterative core.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] DIV0_Q = XLEN'(DIV0_QUOTIENT);

    mdu_state_e        state_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   hi_q, lo_q, rs_q;
    logic              is_div_q, div0_q, neg_res_q, neg_rem_q;
    logic [2*XLEN-1:0] acc;

    mdu_op_e         op;
    logic            is_arith, signed_op, sa, sb, load, step;
    logic [XLEN-1:0] mag_a, mag_b, quo, rem;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op        = mdu_op_e'(op_code);
    assign is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign sa        = signed_op & rs_data[XLEN-1];
    assign sb        = signed_op & rt_data[XLEN-1];
    assign mag_a     = magnitude(rs_data, sa);
    assign mag_b     = magnitude(rt_data, sb);
    assign load      = (state_q == ST_IDLE) && op_valid && !flush && is_arith;
    assign step      = (state_q == ST_CALC) && !flush;
    assign quo       = acc[XLEN-1:0];
    assign rem       = acc[2*XLEN-1:XLEN];

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (load),
        .step_i (step),
        .div_i  (is_div_q),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .acc_o  (acc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rs_q      <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q   <= ST_CALC;
                                count_q   <= '0;
                                rs_q      <= rs_data;
                                is_div_q  <= (op == OP_DIV) || (op == OP_DIVU);
                                div0_q    <= (rt_data == '0);
                                neg_res_q <= sa ^ sb;
                                neg_rem_q <= sa;
                            end
                            OP_MTHI: hi_q <= rs_data;
                            OP_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!flush) begin
                        // Divide-by-zero bypasses sign correction and returns the raw dividend.
                        if (is_div_q && div0_q) begin
                            lo_q <= DIV0_Q;
                            hi_q <= rs_q;
                        end else if (is_div_q) begin
                            lo_q <= neg_res_q ? -quo : quo;
                            hi_q <= neg_rem_q ? -rem : rem;
                        end else begin
                            {hi_q, lo_q} <= neg_res_q ? -acc : acc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized self-checking bench for mdu_hilo against a plain-arithmetic HI/LO model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi, m_lo;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;

    mdu_hilo #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Architectural result of one operation, from integer arithmetic.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT: begin
                p = 64'(sa * sb);
                {m_hi, m_lo} = p;
            end
            MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            DIV: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op (caller is #1 after an edge) and return busy cycles seen plus final hi/lo.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic was_busy,
                          output logic [31:0] ohi, output logic [31:0] olo);
        was_busy = busy;
        op_valid = 1'b1; op_code = op; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        ohi = hi; olo = lo;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; op_valid = 1'b0; op_code = 3'd0; rs_data = '0; rt_data = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{MULT, MULTU, DIV, DIVU, DIVU, DIV};
        logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'd0};
        logic [31:0] el  [6] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        int cyc; logic wb; logic [31:0] oh, ol;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], cyc, wb, oh, ol);
            ref_op(ops[i], as[i], bs[i]);
            tests++;
            if (cyc != 33) begin
                fails++;
                $display("FAIL directed_%0d_latency: busy cycles=%0d, required 33", i, cyc);
            end
            tests++;
            if (oh !== eh[i] || ol !== el[i]) begin
                fails++;
                $display("FAIL directed_%0d_result: hi=%h lo=%h, required hi=%h lo=%h", i, oh, ol, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_mthi_flush();
        int cyc; logic wb; logic [31:0] oh, ol, prior_lo;
        prior_lo = m_lo;
        run_op(MTHI, 32'hA5A5_A5A5, 32'd0, cyc, wb, oh, ol);
        ref_op(MTHI, 32'hA5A5_A5A5, 32'd0);
        tests++;
        if (cyc != 0 || oh !== 32'hA5A5_A5A5 || ol !== prior_lo) begin
            fails++;
            $display("FAIL mthi: busy cycles=%0d hi=%h lo=%h, required 0 %h %h", cyc, oh, ol, 32'hA5A5_A5A5, prior_lo);
        end
        op_valid = 1'b1; op_code = MULT; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre_busy: busy=%b, required 1", busy);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests++;
        if (busy !== 1'b0 || hi !== 32'hA5A5_A5A5 || lo !== prior_lo) begin
            fails++;
            $display("FAIL flush_abort: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, 32'hA5A5_A5A5, prior_lo);
        end
        run_op(MULTU, 32'd3, 32'd4, cyc, wb, oh, ol);
        ref_op(MULTU, 32'd3, 32'd4);
        tests++;
        if (cyc != 33 || oh !== 32'd0 || ol !== 32'd12) begin
            fails++;
            $display("FAIL after_flush_multu: cycles=%0d hi=%h lo=%h, required 33 0 c", cyc, oh, ol);
        end
    endtask

    task automatic test_idle_corner();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op_valid = 1'b1; op_code = DIVU; rs_data = 32'd50; rt_data = 32'd5; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        tests++;
        if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
            fails++;
            $display("FAIL flush_with_issue: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, h0, l0);
        end
        op_valid = 1'b1; op_code = 3'd6; rs_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        op_code = 3'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
            fails++;
            $display("FAIL undefined_op: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, h0, l0);
        end
        op_valid = 1'b1; op_code = MTLO; rs_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        op_valid = 1'b0;
        ref_op(MTLO, 32'h0BAD_F00D, 32'd0);
        tests++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            fails++;
            $display("FAIL mtlo: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic wb; logic [31:0] oh, ol, a, b;
        logic [2:0] op;
        for (int i = 0; i < 12; i++) begin
            op = 3'(i % 6);
            a = $urandom; b = $urandom;
            run_op(op, a, b, cyc, wb, oh, ol);
            ref_op(op, a, b);
            tests++;
            if (wb !== 1'b0) begin
                fails++;
                $display("FAIL b2b_%0d_protocol: issued while busy=%b", i, wb);
            end
            tests++;
            if (cyc != ((op <= DIVU) ? 33 : 0) || oh !== m_hi || ol !== m_lo) begin
                fails++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: cycles=%0d hi=%h lo=%h, required hi=%h lo=%h",
                         i, op, a, b, cyc, oh, ol, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_random();
        int cyc; logic wb; logic [31:0] oh, ol, a, b;
        logic [2:0] op;
        logic [31:0] specials [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 5));
            a = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = specials[$urandom_range(0, 3)];
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, cyc, wb, oh, ol);
            ref_op(op, a, b);
            tests++;
            if (cyc != ((op <= DIVU) ? 33 : 0) || oh !== m_hi || ol !== m_lo) begin
                fails++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: cycles=%0d hi=%h lo=%h, required hi=%h lo=%h",
                         i, op, a, b, cyc, oh, ol, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_midop();
        op_valid = 1'b1; op_code = MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_b = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL async_reset_midop: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL post_reset_idle: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_flush();
        test_idle_corner();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
